// File: rtl/disp_pkg.sv
// Shared types and constants for the display scan controller and its BCD converter.
package disp_pkg;

  localparam int unsigned BcdDigitW = 4;

  typedef enum logic [1:0] {StSet, StWaitDec, StShow} scan_state_e;

  typedef enum logic {StIdle, StShift} conv_state_e;

  // Largest value representable in n decimal digits.
  function automatic int unsigned sat_limit(input int unsigned n);
    int unsigned lim;
    lim = 1;
    for (int unsigned i = 0; i < n; i++) begin
      lim = lim * 10;
    end
    return lim - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift per cycle; BCD is valid in the cycle DONE is high.
module bin2bcd_seq
  import disp_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned VAL_W    = 14
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          START,
  input  logic [VAL_W-1:0]              BIN,
  output logic                          BUSY,
  output logic [BcdDigitW*N_DIGITS-1:0] BCD,
  output logic                          DONE
);

  localparam int unsigned BcdW   = BcdDigitW * N_DIGITS;
  localparam int unsigned CntW   = (VAL_W > 1) ? $clog2(VAL_W) : 1;
  localparam int unsigned SatLim = sat_limit(N_DIGITS);
  localparam logic [CntW-1:0] LastCnt = CntW'(VAL_W - 1);

  conv_state_e      state_q;
  logic [CntW-1:0]  cnt_q;
  logic [VAL_W-1:0] bin_q;
  logic [VAL_W-1:0] bin_sat;
  logic [BcdW-1:0]  work_q;
  logic [BcdW-1:0]  work_adj;
  logic [BcdW-1:0]  work_shift;

  always_comb begin
    bin_sat  = (32'(BIN) > SatLim) ? VAL_W'(SatLim) : BIN;
    work_adj = work_q;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (work_q[i*BcdDigitW +: BcdDigitW] >= 4'd5) begin
        work_adj[i*BcdDigitW +: BcdDigitW] = work_q[i*BcdDigitW +: BcdDigitW] + 4'd3;
      end
    end
    work_shift = BcdW'({work_adj, bin_q[VAL_W-1]});
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bin_q   <= '0;
      work_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (START) begin
            state_q <= StShift;
            cnt_q   <= '0;
            bin_q   <= bin_sat;
            work_q  <= '0;
          end
        end
        StShift: begin
          bin_q  <= bin_q << 1;
          work_q <= work_shift;
          if (cnt_q == LastCnt) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign BUSY = (state_q == StShift);
  assign DONE = (state_q == StShift) && (cnt_q == LastCnt);
  assign BCD  = work_shift;

endmodule

// File: rtl/disp_scan_ctrl.sv
// Converts a binary value to BCD and time-multiplexes the digits onto one 7-segment decoder.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned VAL_W       = 14,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DEC_TIMEOUT = 8,
  parameter bit          LZB         = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [VAL_W-1:0]    VALUE,
  input  logic                LOAD,
  output logic                BUSY,
  output logic [7:0]          DIG_DATA,
  output logic                DEC_EN,
  output logic                DEC_RST,
  input  logic                DEC_WAIT,
  output logic [N_DIGITS-1:0] ANODE,
  output logic                ERR
);

  localparam int unsigned BcdW = BcdDigitW * N_DIGITS;
  localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned RefW = $clog2(REFRESH_DIV) + 1;
  localparam int unsigned TmoW = $clog2(DEC_TIMEOUT) + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_DIGITS - 1);
  localparam logic [RefW-1:0] LastRef = RefW'(REFRESH_DIV - 1);
  localparam logic [TmoW-1:0] LastTmo = TmoW'(DEC_TIMEOUT - 1);

  logic                 conv_busy;
  logic                 conv_done;
  logic [BcdW-1:0]      conv_bcd;
  logic [BcdW-1:0]      bcd_q;

  scan_state_e          state_q;
  logic [IdxW-1:0]      idx_q;
  logic [RefW-1:0]      ref_q;
  logic [TmoW-1:0]      tmo_q;
  logic                 blank_q;
  logic [7:0]           dig_q;
  logic                 dec_en_q;
  logic                 dec_rst_q;
  logic [N_DIGITS-1:0]  anode_q;
  logic                 err_q;

  logic [BcdDigitW-1:0] cur_digit;
  logic                 upper_zero;
  logic [N_DIGITS-1:0]  anode_sel;

  bin2bcd_seq #(
    .N_DIGITS(N_DIGITS),
    .VAL_W   (VAL_W)
  ) u_conv (
    .CLK  (CLK),
    .RST  (RST),
    .START(LOAD),
    .BIN  (VALUE),
    .BUSY (conv_busy),
    .BCD  (conv_bcd),
    .DONE (conv_done)
  );

  // Display register changes only on the final conversion step, so the scan never sees a partial result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bcd_q <= '0;
    end else if (conv_done) begin
      bcd_q <= conv_bcd;
    end
  end

  always_comb begin
    cur_digit  = bcd_q[32'(idx_q) * BcdDigitW +: BcdDigitW];
    upper_zero = (bcd_q >> (32'(idx_q) * BcdDigitW)) == '0;
    anode_sel  = ~(N_DIGITS'(1) << idx_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StSet;
      idx_q     <= '0;
      ref_q     <= '0;
      tmo_q     <= '0;
      blank_q   <= 1'b0;
      dig_q     <= '0;
      dec_en_q  <= 1'b1;
      dec_rst_q <= 1'b1;
      anode_q   <= '1;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StSet: begin
          dig_q     <= {4'b0000, cur_digit};
          blank_q   <= LZB && (idx_q != '0) && upper_zero;
          dec_rst_q <= 1'b0;
          anode_q   <= '1;
          tmo_q     <= '0;
          state_q   <= StWaitDec;
        end
        StWaitDec: begin
          // A stalled decoder still gets its slot so the rest of the display keeps refreshing.
          if (!DEC_WAIT || (tmo_q == LastTmo)) begin
            if (DEC_WAIT) begin
              err_q <= 1'b1;
            end
            state_q <= StShow;
            ref_q   <= '0;
            anode_q <= blank_q ? '1 : anode_sel;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StShow: begin
          if (ref_q == LastRef) begin
            state_q   <= StSet;
            dec_rst_q <= 1'b1;
            anode_q   <= '1;
            idx_q     <= (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
          end else begin
            ref_q <= ref_q + 1'b1;
          end
        end
        default: state_q <= StSet;
      endcase
    end
  end

  assign BUSY     = conv_busy;
  assign DIG_DATA = dig_q;
  assign DEC_EN   = dec_en_q;
  assign DEC_RST  = dec_rst_q;
  assign ANODE    = anode_q;
  assign ERR      = err_q;

endmodule
